// File: rtl/endnode_link_sender.sv
// Switch-side TX driver toward an endnode: forwards queued packets under per-VC credit
// control and injects ACK komma flits ahead of data whenever the RX side requests one.
module endnode_link_sender #(
    parameter int FLIT_W     = 32,
    parameter int NVC        = 2,
    parameter int CREDIT_MAX = 8,
    parameter int ACK_DEPTH  = 3,
    localparam int VC_W = (NVC > 1) ? $clog2(NVC) : 1,
    localparam int CW   = $clog2(CREDIT_MAX + 1),
    localparam int AW   = $clog2(ACK_DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              in_valid,
    input  logic [FLIT_W-1:0] in_flit,
    input  logic              in_sof,
    input  logic              in_eof,
    input  logic [VC_W-1:0]   in_vc,
    output logic              in_ready,
    input  logic              ack_req,
    input  logic [FLIT_W-1:0] ack_flit,
    input  logic [NVC-1:0]    grtcred_rx,
    input  logic              get_data,
    output logic [FLIT_W-1:0] flit_tx,
    output logic              start_tx,
    output logic              send_next_flit_tx,
    output logic              done_tx,
    output logic              packet_done_tx,
    output logic [NVC*CW-1:0] credit_cnt,
    output logic              proto_err
);

    typedef enum logic [1:0] {
        IDLE,
        ACK_WAIT,
        DATA_WAIT,
        FETCH
    } state_t;

    state_t          state_reg;
    logic [AW-1:0]   ack_cnt_reg;
    logic [CW-1:0]   credit_arr [NVC];
    logic [CW-1:0]   head_credit;
    logic            vc_ok;
    logic            ack_pending;
    logic            launch_ack;
    logic            launch_data;
    logic            drop_flit;
    logic            ack_done;
    logic            data_done;
    logic            ack_overflow;

    assign vc_ok       = int'(in_vc) < NVC;
    assign head_credit = vc_ok ? credit_arr[in_vc] : '0;

    // An ack_req arriving while idle is served at once so it beats a waiting sof.
    assign ack_pending = (ack_cnt_reg != '0) || ack_req;
    assign launch_ack  = (state_reg == IDLE) && ack_pending;
    assign launch_data = (state_reg == IDLE) && !ack_pending && in_valid && in_sof &&
                         (head_credit != '0);
    assign drop_flit   = (state_reg == IDLE) && !ack_pending && in_valid && !in_sof;
    assign ack_done    = (state_reg == ACK_WAIT) && get_data;
    assign data_done   = (state_reg == DATA_WAIT) && get_data;

    // The queue head is only popped once the phy has taken it, so in_eof still
    // describes the flit being handed off.
    assign in_ready       = drop_flit || data_done;
    assign done_tx        = ack_done || data_done;
    assign packet_done_tx = ack_done || (data_done && in_eof);

    // An ACK stays counted until its flit is handed off.
    assign ack_overflow = ack_req && !ack_done && (ack_cnt_reg == AW'(ACK_DEPTH));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ack_cnt_reg <= '0;
        end else if (ack_req && !ack_done && !ack_overflow) begin
            ack_cnt_reg <= ack_cnt_reg + AW'(1);
        end else if (!ack_req && ack_done) begin
            ack_cnt_reg <= ack_cnt_reg - AW'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg         <= IDLE;
            flit_tx           <= '0;
            start_tx          <= 1'b0;
            send_next_flit_tx <= 1'b0;
            proto_err         <= 1'b0;
        end else begin
            start_tx          <= 1'b0;
            send_next_flit_tx <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (launch_ack) begin
                        flit_tx   <= ack_flit;
                        start_tx  <= 1'b1;
                        state_reg <= ACK_WAIT;
                    end else if (launch_data) begin
                        flit_tx   <= in_flit;
                        start_tx  <= 1'b1;
                        state_reg <= DATA_WAIT;
                    end else if (drop_flit) begin
                        proto_err <= 1'b1;
                    end
                end
                ACK_WAIT: begin
                    if (get_data) begin
                        state_reg <= IDLE;
                    end
                end
                DATA_WAIT: begin
                    if (get_data) begin
                        state_reg <= in_eof ? IDLE : FETCH;
                    end
                end
                FETCH: begin
                    if (in_valid) begin
                        flit_tx           <= in_flit;
                        send_next_flit_tx <= 1'b1;
                        state_reg         <= DATA_WAIT;
                        if (in_sof) begin
                            proto_err <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
            if (ack_overflow) begin
                proto_err <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NVC; gi++) begin : g_credit
            logic [CW-1:0] cnt_reg;
            logic          dec;

            assign dec = launch_data && (in_vc == VC_W'(gi));

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    cnt_reg <= CW'(CREDIT_MAX);
                end else if (grtcred_rx[gi] && !dec) begin
                    if (cnt_reg != CW'(CREDIT_MAX)) begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end else if (dec && !grtcred_rx[gi]) begin
                    cnt_reg <= cnt_reg - CW'(1);
                end
            end

            assign credit_arr[gi]          = cnt_reg;
            assign credit_cnt[gi*CW +: CW] = cnt_reg;
        end
    endgenerate

endmodule

// File: tb/tb_endnode_link_sender.sv
// Bench for endnode_link_sender: switch-queue and phy models drive the DUT, a monitor
// checks every handed-off flit against a queue of expected flits.
module tb_endnode_link_sender;

    localparam int FLIT_W = 32;
    localparam int NVC    = 2;
    localparam int CW     = 4;
    localparam logic [FLIT_W-1:0] ACK_WORD = 32'hACC0_0001;

    logic              CLK;
    logic              nRST;
    logic              in_valid;
    logic [FLIT_W-1:0] in_flit;
    logic              in_sof;
    logic              in_eof;
    logic              in_vc;
    logic              in_ready;
    logic              ack_req;
    logic [FLIT_W-1:0] ack_flit;
    logic [NVC-1:0]    grtcred_rx;
    logic              get_data;
    logic [FLIT_W-1:0] flit_tx;
    logic              start_tx;
    logic              send_next_flit_tx;
    logic              done_tx;
    logic              packet_done_tx;
    logic [NVC*CW-1:0] credit_cnt;
    logic              proto_err;

    endnode_link_sender dut (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_flit(in_flit), .in_sof(in_sof), .in_eof(in_eof),
        .in_vc(in_vc), .in_ready(in_ready),
        .ack_req(ack_req), .ack_flit(ack_flit), .grtcred_rx(grtcred_rx),
        .get_data(get_data), .flit_tx(flit_tx), .start_tx(start_tx),
        .send_next_flit_tx(send_next_flit_tx), .done_tx(done_tx),
        .packet_done_tx(packet_done_tx), .credit_cnt(credit_cnt), .proto_err(proto_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [FLIT_W-1:0] flit;
        logic              sof;
        logic              eof;
        logic              vc;
    } src_t;

    typedef struct {
        logic [FLIT_W-1:0] flit;
        logic              last;
    } exp_t;

    src_t src_q[$];
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int start_cnt = 0, sn_cnt = 0, done_cnt = 0, pd_cnt = 0;
    int phy_timer = 0;
    bit phy_en = 1'b0;
    bit pop_now;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every handed-off flit must match the oldest expected entry.
    always @(negedge CLK) begin
        if (nRST) begin
            if (start_tx) start_cnt++;
            if (send_next_flit_tx) sn_cnt++;
            if (packet_done_tx) pd_cnt++;
            if (done_tx) begin
                exp_t e;
                done_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got flit %0h expected no hand-off", flit_tx);
                end else begin
                    e = exp_q.pop_front();
                    chk("flit_tx", 64'(flit_tx), 64'(e.flit));
                    chk("packet_done_tx", 64'(packet_done_tx), 64'(e.last));
                    $display("xfer flit=%h last=%0d", flit_tx, packet_done_tx);
                end
            end else if (packet_done_tx) begin
                chk("packet_done_without_done", 64'(packet_done_tx), 64'(done_tx));
            end
        end
    end

    task automatic drive_head();
        if (src_q.size() > 0) begin
            in_valid = 1'b1;
            in_flit  = src_q[0].flit;
            in_sof   = src_q[0].sof;
            in_eof   = src_q[0].eof;
            in_vc    = src_q[0].vc;
        end else begin
            in_valid = 1'b0;
            in_flit  = '0;
            in_sof   = 1'b0;
            in_eof   = 1'b0;
            in_vc    = 1'b0;
        end
    endtask

    // One clock: sample handshakes mid-cycle, then update queue head and phy after the edge.
    task automatic cycle();
        @(negedge CLK);
        pop_now = in_ready && in_valid;
        if (phy_en && (start_tx || send_next_flit_tx)) phy_timer = 2;
        @(posedge CLK);
        #1;
        ack_req    = 1'b0;
        grtcred_rx = '0;
        get_data   = 1'b0;
        if (pop_now && src_q.size() > 0) src_q.delete(0);
        if (phy_timer > 0) begin
            phy_timer--;
            if (phy_timer == 0) get_data = 1'b1;
        end
        drive_head();
    endtask

    task automatic push_pkt(input int n, input logic vc, input logic [FLIT_W-1:0] base);
        for (int i = 0; i < n; i++) begin
            src_t s;
            exp_t e;
            s.flit = base + FLIT_W'(i);
            s.sof  = (i == 0);
            s.eof  = (i == n - 1);
            s.vc   = vc;
            src_q.push_back(s);
            e.flit = s.flit;
            e.last = s.eof;
            exp_q.push_back(e);
        end
        drive_head();
    endtask

    task automatic push_ack();
        exp_t e;
        e.flit = ACK_WORD;
        e.last = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic wait_pd(input int target, input int budget, input string what);
        int n = 0;
        while (pd_cnt < target && n < budget) begin
            cycle();
            n++;
        end
        chk(what, 64'(pd_cnt >= target), 64'd1);
    endtask

    task automatic apply_reset();
        nRST = 1'b0;
        exp_q.delete();
        src_q.delete();
        phy_timer  = 0;
        get_data   = 1'b0;
        ack_req    = 1'b0;
        grtcred_rx = '0;
        drive_head();
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        nRST = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int s0;
        int p0;
        ack_flit = ACK_WORD;
        apply_reset();

        // Reset state
        chk("rst_flit_tx", 64'(flit_tx), 64'd0);
        chk("rst_start_tx", 64'(start_tx), 64'd0);
        chk("rst_send_next", 64'(send_next_flit_tx), 64'd0);
        chk("rst_done_tx", 64'(done_tx), 64'd0);
        chk("rst_packet_done", 64'(packet_done_tx), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_credit", 64'(credit_cnt), 64'h88);
        chk("rst_proto_err", 64'(proto_err), 64'd0);

        // 3-flit packet on VC0
        phy_en = 1'b1;
        push_pkt(3, 1'b0, 32'h0000_1001);
        wait_pd(1, 60, "pkt3_timeout");
        repeat (2) cycle();
        chk("pkt3_start_cnt", 64'(start_cnt), 64'd1);
        chk("pkt3_send_next_cnt", 64'(sn_cnt), 64'd2);
        chk("pkt3_done_cnt", 64'(done_cnt), 64'd3);
        chk("pkt3_credit0", 64'(credit_cnt[3:0]), 64'd7);
        chk("pkt3_exp_empty", 64'(exp_q.size()), 64'd0);

        // Credit return: VC0 7->8, VC1 saturated at 8
        grtcred_rx = 2'b11;
        cycle();
        chk("grt_credit0", 64'(credit_cnt[3:0]), 64'd8);
        chk("grt_sat_credit1", 64'(credit_cnt[7:4]), 64'd8);

        // ACK request in the same cycle as a VC1 sof: ACK goes first
        s0 = start_cnt;
        p0 = pd_cnt;
        push_ack();
        push_pkt(1, 1'b1, 32'h0000_2001);
        ack_req = 1'b1;
        cycle();
        wait_pd(p0 + 2, 60, "ack_first_timeout");
        chk("ack_first_starts", 64'(start_cnt - s0), 64'd2);
        chk("ack_first_credit1", 64'(credit_cnt[7:4]), 64'd7);

        // Credit return on VC1 during a VC1 launch leaves credit1 unchanged
        p0 = pd_cnt;
        push_pkt(1, 1'b1, 32'h0000_2101);
        grtcred_rx = 2'b10;
        cycle();
        chk("incdec_credit1", 64'(credit_cnt[7:4]), 64'd7);
        wait_pd(p0 + 1, 40, "incdec_timeout");
        chk("incdec_credit1_after", 64'(credit_cnt[7:4]), 64'd7);

        // Credit exhaustion on VC0: 9th packet stalls until one credit returns
        apply_reset();
        phy_en = 1'b1;
        s0 = start_cnt;
        p0 = pd_cnt;
        for (int i = 0; i < 9; i++) push_pkt(1, 1'b0, 32'h0000_3000 + FLIT_W'(i));
        wait_pd(p0 + 8, 300, "credit8_timeout");
        repeat (5) cycle();
        chk("stall_in_valid", 64'(in_valid), 64'd1);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_credit0", 64'(credit_cnt[3:0]), 64'd0);
        chk("stall_starts", 64'(start_cnt - s0), 64'd8);
        chk("stall_exp_left", 64'(exp_q.size()), 64'd1);
        grtcred_rx = 2'b01;
        cycle();
        wait_pd(p0 + 9, 40, "release_timeout");
        chk("release_credit0", 64'(credit_cnt[3:0]), 64'd0);
        chk("release_starts", 64'(start_cnt - s0), 64'd9);

        // ACK overflow: four requests, phy silent, depth three
        apply_reset();
        phy_en = 1'b0;
        s0 = start_cnt;
        p0 = pd_cnt;
        for (int i = 0; i < 3; i++) push_ack();
        for (int i = 0; i < 4; i++) begin
            ack_req = 1'b1;
            cycle();
            if (i == 2) chk("ack3_no_err", 64'(proto_err), 64'd0);
        end
        chk("ack4_overflow_err", 64'(proto_err), 64'd1);
        for (int i = 0; i < 3; i++) begin
            get_data = 1'b1;
            cycle();
            repeat (3) cycle();
        end
        repeat (6) cycle();
        chk("ack_packet_dones", 64'(pd_cnt - p0), 64'd3);
        chk("ack_starts", 64'(start_cnt - s0), 64'd3);

        // Asynchronous reset while in DATA_WAIT mid-packet
        apply_reset();
        phy_en = 1'b1;
        s0 = start_cnt;
        push_pkt(3, 1'b0, 32'h0000_4001);
        for (int n = 0; n < 20 && start_cnt == s0; n++) cycle();
        chk("midpkt_started", 64'(start_cnt - s0), 64'd1);
        p0 = pd_cnt;
        nRST = 1'b0;
        #1;
        chk("midrst_flit_tx", 64'(flit_tx), 64'd0);
        chk("midrst_done_tx", 64'(done_tx), 64'd0);
        chk("midrst_send_next", 64'(send_next_flit_tx), 64'd0);
        chk("midrst_credit", 64'(credit_cnt), 64'h88);
        apply_reset();
        repeat (10) cycle();
        chk("midrst_no_packet_done", 64'(pd_cnt - p0), 64'd0);
        chk("midrst_proto_err", 64'(proto_err), 64'd0);

        // Non-sof flit in IDLE is dropped and flags a protocol error
        begin
            src_t s;
            s.flit = 32'h0000_5001;
            s.sof  = 1'b0;
            s.eof  = 1'b0;
            s.vc   = 1'b0;
            src_q.push_back(s);
            drive_head();
        end
        s0 = start_cnt;
        #1;
        chk("drop_in_ready", 64'(in_ready), 64'd1);
        cycle();
        chk("drop_proto_err", 64'(proto_err), 64'd1);
        chk("drop_popped", 64'(src_q.size()), 64'd0);
        repeat (3) cycle();
        chk("drop_no_start", 64'(start_cnt - s0), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
